// File: rtl/load_unit_pkg.sv
// Shared definitions for the RV32I load executor: opcode/func3 encodings,
// FSM state type and the legality check applied when a load is launched.
package load_unit_pkg;

    localparam logic [6:0] OPC_LOAD = 7'b0000011;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_WB,
        ST_FAULT
    } state_t;

    // 1 when the load cannot be executed: unknown func3 or a misaligned half/word.
    function automatic logic load_bad(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_LB, F3_LBU: return 1'b0;
            F3_LH, F3_LHU: return lo[0];
            F3_LW:         return (lo != 2'b00);
            default:       return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_extract.sv
// Lane select and sign/zero extension of a RAM word for RV32I loads.
// Purely combinational so it can be shared by later bypass paths.
module load_extract
    import load_unit_pkg::*;
(
    input  logic [2:0]  i_func3,
    input  logic [1:0]  i_lo,
    input  logic [31:0] i_word,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_lo, 3'b000} +: 8];
    assign w_half = i_lo[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_result = i_word;
        case (i_func3)
            F3_LB:   o_result = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  o_result = {24'b0, w_byte};
            F3_LH:   o_result = {{16{w_half[15]}}, w_half};
            F3_LHU:  o_result = {16'b0, w_half};
            default: o_result = i_word;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Multi-cycle RV32I load executor: address generation, word read from data RAM
// with configurable latency, lane extraction and register-file writeback.
module load_unit
    import load_unit_pkg::*;
#(
    parameter int RAM_ADDR_W  = 8,
    parameter int RAM_LATENCY = 1
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iSTART,
    input  logic [31:0]           iIR,
    input  logic [31:0]           iREG_OUT1,
    output logic [4:0]            oRS1,
    output logic [4:0]            oRD,
    output logic [31:0]           oREG_IN,
    output logic                  oREG_WE,
    output logic                  oRAM_CE,
    output logic                  oRAM_RD,
    output logic                  oRAM_WR,
    output logic [RAM_ADDR_W-1:0] oRAM_ADDR,
    input  logic [31:0]           iRAM_DATA,
    output logic                  oBUSY,
    output logic                  oDONE,
    output logic                  oFAULT
);

    localparam int AW = RAM_ADDR_W + 2;
    localparam int CW = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;

    state_t          r_state;
    logic [2:0]      r_func3;
    logic [4:0]      r_rd;
    logic [AW-1:0]   r_addr;
    logic [31:0]     r_data;
    logic [CW-1:0]   r_cnt;

    logic [31:0]     w_addr;
    logic [31:0]     w_ext;
    logic            w_unused;

    // Only the word address and byte offset are kept; higher bits wrap away.
    assign w_addr   = iREG_OUT1 + {{20{iIR[31]}}, iIR[31:20]};
    assign w_unused = &{1'b0, iIR[6:0], w_addr[31:AW]};

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= ST_IDLE;
            r_func3 <= '0;
            r_rd    <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (iSTART) begin
                    r_func3 <= iIR[14:12];
                    r_rd    <= iIR[11:7];
                    r_addr  <= w_addr[AW-1:0];
                    r_state <= load_bad(iIR[14:12], w_addr[1:0]) ? ST_FAULT : ST_REQ;
                end
                ST_REQ: begin
                    r_cnt   <= CW'(RAM_LATENCY - 1);
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_data  <= iRAM_DATA;
                        r_state <= ST_WB;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_WB, ST_FAULT: r_state <= ST_IDLE;
                default:         r_state <= ST_IDLE;
            endcase
        end
    end

    load_extract u_extract (
        .i_func3  (r_func3),
        .i_lo     (r_addr[1:0]),
        .i_word   (r_data),
        .o_result (w_ext)
    );

    assign oRS1      = iIR[19:15];
    assign oRD       = r_rd;
    assign oRAM_ADDR = r_addr[AW-1:2];
    assign oRAM_CE   = (r_state == ST_REQ) || (r_state == ST_WAIT);
    assign oRAM_RD   = oRAM_CE;
    assign oRAM_WR   = 1'b0;
    assign oBUSY     = (r_state != ST_IDLE);
    assign oDONE     = (r_state == ST_WB) || (r_state == ST_FAULT);
    assign oFAULT    = (r_state == ST_FAULT);
    assign oREG_WE   = (r_state == ST_WB) && (r_rd != 5'd0);
    assign oREG_IN   = (r_state == ST_WB) ? w_ext : 32'd0;

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: one instance with RAM_LATENCY=1, one with 3,
// each fed by a small latency-matched RAM model.
module tb_load_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, start3;
    logic [31:0] ir, rs1v;

    logic [4:0]  rs1_1, rd_1, rs1_3, rd_3;
    logic [31:0] regin_1, regin_3, rdata_1, rdata_3;
    logic        we_1, ce_1, rd_en_1, wr_1, busy_1, done_1, fault_1;
    logic        we_3, ce_3, rd_en_3, wr_3, busy_3, done_3, fault_3;
    logic [7:0]  addr_1, addr_3;

    logic [31:0] mem [256];
    logic [31:0] q3 [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_unit #(.RAM_ADDR_W(8), .RAM_LATENCY(1)) u1 (
        .iCLK(clk), .iRST(rst), .iSTART(start1), .iIR(ir), .iREG_OUT1(rs1v),
        .oRS1(rs1_1), .oRD(rd_1), .oREG_IN(regin_1), .oREG_WE(we_1),
        .oRAM_CE(ce_1), .oRAM_RD(rd_en_1), .oRAM_WR(wr_1), .oRAM_ADDR(addr_1),
        .iRAM_DATA(rdata_1), .oBUSY(busy_1), .oDONE(done_1), .oFAULT(fault_1)
    );

    load_unit #(.RAM_ADDR_W(8), .RAM_LATENCY(3)) u3 (
        .iCLK(clk), .iRST(rst), .iSTART(start3), .iIR(ir), .iREG_OUT1(rs1v),
        .oRS1(rs1_3), .oRD(rd_3), .oREG_IN(regin_3), .oREG_WE(we_3),
        .oRAM_CE(ce_3), .oRAM_RD(rd_en_3), .oRAM_WR(wr_3), .oRAM_ADDR(addr_3),
        .iRAM_DATA(rdata_3), .oBUSY(busy_3), .oDONE(done_3), .oFAULT(fault_3)
    );

    // RAM returns zero when not read, so a mistimed capture shows up as 0.
    always @(posedge clk) begin
        rdata_1 <= (ce_1 && rd_en_1) ? mem[addr_1] : 32'd0;
        q3[0]   <= (ce_3 && rd_en_3) ? mem[addr_3] : 32'd0;
        q3[1]   <= q3[0];
        q3[2]   <= q3[1];
    end
    assign rdata_3 = q3[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd);
        return {imm, 5'd1, f3, rd, 7'b0000011};
    endfunction

    // Launch on u1 from an IDLE negedge and follow it to completion.
    task automatic run1(input string tag, input logic [11:0] imm, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [31:0] base,
                        input logic [7:0] exp_addr, input logic [31:0] exp_val,
                        input logic exp_fault);
        int n;
        logic ce_seen;
        ir = mk(imm, f3, rd); rs1v = base; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 1; ce_seen = 1'b0;
        if (!exp_fault) chk({tag, ".addr"}, {24'd0, addr_1}, {24'd0, exp_addr});
        while (!done_1 && n < 12) begin
            ce_seen |= ce_1;
            @(negedge clk);
            n++;
        end
        chk({tag, ".cycles"}, n, exp_fault ? 1 : 3);
        chk({tag, ".fault"}, {31'd0, fault_1}, {31'd0, exp_fault});
        chk({tag, ".we"}, {31'd0, we_1}, {31'd0, !exp_fault && rd != 5'd0});
        chk({tag, ".rd"}, {27'd0, rd_1}, {27'd0, rd});
        if (exp_fault) chk({tag, ".ce"}, {31'd0, ce_seen | ce_1}, 32'd0);
        else if (rd != 5'd0) chk({tag, ".val"}, regin_1, exp_val);
        @(negedge clk);
        chk({tag, ".idle"}, {30'd0, busy_1, done_1}, 32'd0);
    endtask

    initial begin
        int n, dcnt, wecnt;
        logic [31:0] last_in;
        logic [4:0]  last_rd;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[5]  = 32'hDEADBEEF;
        mem[8]  = 32'h9ABC1234;
        mem[12] = 32'h80FF7F01;
        rst = 1'b1; start1 = 1'b0; start3 = 1'b0; ir = mk(12'd0, 3'd2, 5'd1); rs1v = 32'd0;
        repeat (3) @(negedge clk);

        chk("rst.u1", {regin_1, busy_1, done_1, we_1, ce_1, rd_en_1, wr_1, fault_1, rd_1, addr_1} == '0, 1'b1);
        chk("rst.u3", {regin_3, busy_3, done_3, we_3, ce_3, fault_3, rd_3} == '0, 1'b1);
        chk("rs1.field", {27'd0, rs1_1}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        run1("lw",      12'd4,   3'd2, 5'd3, 32'h10,  8'd5,   32'hDEADBEEF, 1'b0);
        run1("lb3",     12'd3,   3'd0, 5'd4, 32'h30,  8'd12,  32'hFFFFFF80, 1'b0);
        run1("lbu3",    12'd3,   3'd4, 5'd4, 32'h30,  8'd12,  32'h00000080, 1'b0);
        run1("lb0",     12'd0,   3'd0, 5'd4, 32'h30,  8'd12,  32'h00000001, 1'b0);
        run1("lb1",     12'd1,   3'd0, 5'd9, 32'h30,  8'd12,  32'h0000007F, 1'b0);
        run1("lbu2",    12'd2,   3'd4, 5'd9, 32'h30,  8'd12,  32'h000000FF, 1'b0);
        run1("lh22",    12'hFFE, 3'd1, 5'd5, 32'h24,  8'd8,   32'hFFFF9ABC, 1'b0);
        run1("lhu20",   12'd0,   3'd5, 5'd5, 32'h20,  8'd8,   32'h00001234, 1'b0);
        run1("lhu22",   12'd2,   3'd5, 5'd5, 32'h20,  8'd8,   32'h00009ABC, 1'b0);
        run1("lh20",    12'd0,   3'd1, 5'd5, 32'h20,  8'd8,   32'h00001234, 1'b0);
        run1("wrap",    12'd0,   3'd2, 5'd6, 32'h414, 8'd5,   32'hDEADBEEF, 1'b0);
        run1("lw_mis",  12'd3,   3'd2, 5'd3, 32'h10,  8'd0,   32'd0,        1'b1);
        run1("f3_3",    12'd0,   3'd3, 5'd3, 32'h20,  8'd0,   32'd0,        1'b1);
        run1("f3_6",    12'd0,   3'd6, 5'd3, 32'h20,  8'd0,   32'd0,        1'b1);
        run1("f3_7",    12'd0,   3'd7, 5'd3, 32'h20,  8'd0,   32'd0,        1'b1);
        run1("lh_mis",  12'd1,   3'd1, 5'd3, 32'h20,  8'd0,   32'd0,        1'b1);
        run1("rd0",     12'd4,   3'd2, 5'd0, 32'h10,  8'd5,   32'd0,        1'b0);

        // start held while busy, with a different instruction on the bus
        ir = mk(12'd4, 3'd2, 5'd5); rs1v = 32'h10; start1 = 1'b1;
        dcnt = 0; last_in = 32'd0; last_rd = 5'd0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) begin ir = mk(12'd3, 3'd0, 5'd6); rs1v = 32'h30; end
            if (i == 3) start1 = 1'b0;
            if (done_1) begin dcnt++; last_in = regin_1; last_rd = rd_1; end
        end
        chk("busy.done_cnt", dcnt, 1);
        chk("busy.val", last_in, 32'hDEADBEEF);
        chk("busy.rd", {27'd0, last_rd}, 32'd5);

        // RAM_LATENCY=3
        ir = mk(12'd4, 3'd2, 5'd3); rs1v = 32'h10; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0; n = 1;
        while (!done_3 && n < 15) begin @(negedge clk); n++; end
        chk("lat3.cycles", n, 5);
        chk("lat3.val", regin_3, 32'hDEADBEEF);
        chk("lat3.we", {31'd0, we_3}, 32'd1);
        @(negedge clk);

        // reset during WAIT on both instances
        ir = mk(12'd4, 3'd2, 5'd7); rs1v = 32'h10; start1 = 1'b1; start3 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; start3 = 1'b0;
        @(negedge clk);
        chk("abort.in_wait", {30'd0, busy_1, busy_3}, 32'd3);
        rst = 1'b1;
        @(negedge clk);
        chk("abort.u1", {regin_1, busy_1, done_1, we_1, ce_1, rd_en_1, fault_1, rd_1, addr_1} == '0, 1'b1);
        chk("abort.u3", {regin_3, busy_3, done_3, we_3, ce_3, rd_en_3, fault_3, rd_3, addr_3} == '0, 1'b1);
        rst = 1'b0;
        wecnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done_1 || we_1 || done_3 || we_3) wecnt++;
        end
        chk("abort.quiet", wecnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
